osd_tracesample_mc: RTL and testbench
=====================================

OSD_TRACESAMPLE_MC -- requirements
Module: osd_tracesample_mc

Interface
REQ-001 Parameter WIDTH, default 16: sample/output payload width in bits; WIDTH >= OVW.
REQ-002 Parameter NCH, default 4: number of independent sample channels; NCH >= 1.
REQ-003 Parameter OVW, default 10: overflow counter width in bits; OVW >= 2.
REQ-004 Derived constant CHW = max(1, clog2(NCH)): channel index width.
REQ-005 clk  in  1  single clock; all state on rising edge.
REQ-006 rst_n  in  1  reset, asynchronous assert, active-low.
REQ-007 sample_data  in  NCH*WIDTH  channel i payload at bits [i*WIDTH +: WIDTH].
REQ-008 sample_valid  in  NCH  per-channel sample strobe; no backpressure to sources.
REQ-009 out_data  out  WIDTH  sample payload, or overflow count zero-extended.
REQ-010 out_chan  out  CHW  channel index of the current output word.
REQ-011 out_overflow  out  1  high = overflow message, low = sample.
REQ-012 out_valid  out  1  output word valid.
REQ-013 out_ready  in  1  sink accepts; transfer = out_valid & out_ready.

Function
REQ-014 Each channel SHALL be in one of four states: IDLE (buffer empty, cnt=0), DATA (buffer full, cnt=0), DATA_OV (buffer full, cnt>0), OV (buffer empty, cnt>0).
REQ-015 IDLE: sample_valid -> capture into buffer, go to DATA.
REQ-016 DATA, transferred this cycle: sample_valid -> capture the new sample, stay in DATA; otherwise go to IDLE.
REQ-017 DATA, not transferred: sample_valid -> drop the sample, cnt=1, go to DATA_OV.
REQ-018 DATA_OV, transferred (the buffered sample is sent): go to OV; a sample_valid in the same cycle increments cnt.
REQ-019 DATA_OV or OV, not transferred: sample_valid -> cnt increments, saturating at all-ones (2^OVW-1).
REQ-020 OV, transferred (the overflow message is sent): cnt=0; sample_valid in the same cycle -> capture, go to DATA; otherwise go to IDLE.
REQ-021 Channel request SHALL be high in DATA, DATA_OV and OV.
REQ-022 Request payload: in DATA/DATA_OV, the buffered sample with overflow=0; in OV, the live cnt in out_data[OVW-1:0], upper bits 0, overflow=1.
REQ-023 Ordering per channel: the buffered sample always precedes the overflow message counting drops that occurred after it.
REQ-024 Minimum latency from sample_valid to out_valid is 1 cycle (registered buffer); no combinational path from sample_* to out_*.
REQ-025 The arbiter SHALL use round-robin among requesting channels, starting from the channel after the last transferred one; after reset, priority starts at channel 0.
REQ-026 The grant SHALL be locked while out_valid & !out_ready; out_chan and out_overflow stay stable until transfer.
REQ-027 While an overflow message is stalled, out_data MAY increase (live cnt); the sample payload SHALL stay stable.
REQ-028 out_valid = OR of all channel requests; no idle bubble between back-to-back transfers.
REQ-029 Simultaneous sample_valid on all channels SHALL be handled independently per channel; no cross-channel drop.

Reset
REQ-030 While rst_n=0: all channels IDLE, cnt=0, round-robin pointer = 0.
REQ-031 While rst_n=0: out_valid=0, out_overflow=0, out_chan=0, out_data=0.
REQ-032 Reset mid-operation SHALL discard buffered samples and pending counts; no overflow message is emitted for them.

Structure
REQ-033 Package osd_tracesample_pkg SHALL hold the channel state enum and the CHW computation function.
REQ-034 Per-channel logic SHALL be the sub-module osd_tracesample_chan, instantiated NCH times.
REQ-035 The arbiter and output mux SHALL live in the top module.

Verification
REQ-036 NCH=1, out_ready=1, sample 0x1234 at cycle t -> out_data=0x1234, out_overflow=0 at t+1.
REQ-037 NCH=1, out_ready=0, samples A then 3 more -> A held; after ready rises: A, then overflow message with out_data=3, then IDLE.
REQ-038 OVW=4, out_ready=0, 20 samples after the buffered one -> overflow message out_data=15 (saturated).
REQ-039 NCH=4, all channels sample every cycle, out_ready=1 -> out_chan sequence 0,1,2,3,0,...; each channel's drop count in its overflow message matches the bench model.
REQ-040 OV state with out_ready=1 and sample_valid in the same cycle -> overflow message sent, new sample emitted next, no extra drop counted.
REQ-041 rst_n pulled low with all channels in DATA_OV -> out_valid=0 asynchronously; after release no stale word appears.

Source files
------------

// File: rtl/osd_tracesample_pkg.sv
// Shared types and helpers for the multi-channel trace sampler.
//   chan_state_e : per-channel buffer/overflow state
//   chw_calc     : channel index width, max(1, clog2(n))
package osd_tracesample_pkg;

    typedef enum logic [1:0] {
        CH_IDLE    = 2'd0,  // buffer empty, no pending drops
        CH_DATA    = 2'd1,  // buffer full, no pending drops
        CH_DATA_OV = 2'd2,  // buffer full, drops counted after it
        CH_OV      = 2'd3   // buffer empty, drop count pending
    } chan_state_e;

    function automatic int unsigned chw_calc(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/osd_tracesample_chan.sv
// One sampling channel: a single-entry sample buffer plus a saturating
// drop counter. Samples arriving while the buffer is full (or while a drop
// count is still pending) are counted instead of stored, so the buffered
// sample always precedes the overflow message that counts later drops.
// Ports:
//   clk, rst_n      clock, async active-low reset
//   sample_data     incoming payload
//   sample_valid    incoming strobe (no backpressure)
//   xfer            this channel's request was accepted this cycle
//   req             channel has a word to send
//   req_data        buffered sample, or zero-extended drop count
//   req_overflow    request is an overflow message
module osd_tracesample_chan
    import osd_tracesample_pkg::*;
#(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned OVW   = 10
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] sample_data,
    input  logic             sample_valid,
    input  logic             xfer,
    output logic             req,
    output logic [WIDTH-1:0] req_data,
    output logic             req_overflow
);

    localparam logic [OVW-1:0] CNT_MAX = '1;

    chan_state_e      state_q, state_d;
    logic [WIDTH-1:0] sbuf_q, sbuf_d;
    logic [OVW-1:0]   cnt_q, cnt_d;
    logic [OVW-1:0]   cnt_inc;

    assign cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + OVW'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= CH_IDLE;
            sbuf_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            sbuf_q  <= sbuf_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        sbuf_d  = sbuf_q;
        cnt_d   = cnt_q;
        case (state_q)
            CH_IDLE: begin
                if (sample_valid) begin
                    sbuf_d  = sample_data;
                    state_d = CH_DATA;
                end
            end
            CH_DATA: begin
                if (xfer) begin
                    if (sample_valid) sbuf_d = sample_data;
                    else              state_d = CH_IDLE;
                end else if (sample_valid) begin
                    cnt_d   = OVW'(1);
                    state_d = CH_DATA_OV;
                end
            end
            CH_DATA_OV: begin
                // The buffer is freed by the transfer, but a drop count is
                // already pending, so a same-cycle sample is still a drop.
                if (sample_valid) cnt_d = cnt_inc;
                if (xfer)         state_d = CH_OV;
            end
            CH_OV: begin
                if (xfer) begin
                    cnt_d = '0;
                    if (sample_valid) begin
                        sbuf_d  = sample_data;
                        state_d = CH_DATA;
                    end else begin
                        state_d = CH_IDLE;
                    end
                end else if (sample_valid) begin
                    cnt_d = cnt_inc;
                end
            end
            default: state_d = CH_IDLE;
        endcase
    end

    always_comb begin
        req          = (state_q != CH_IDLE);
        req_overflow = (state_q == CH_OV);
        req_data     = (state_q == CH_OV) ? WIDTH'(cnt_q) : sbuf_q;
    end

endmodule

// File: rtl/osd_tracesample_mc.sv
// Multi-channel trace sampler: NCH independent sampling channels merged
// onto one valid/ready output stream by a round-robin arbiter. The grant is
// held while a word is stalled so channel and message kind stay stable.
// Ports:
//   clk, rst_n     clock, async active-low reset
//   sample_data    NCH packed payloads, channel i at [i*WIDTH +: WIDTH]
//   sample_valid   per-channel strobes
//   out_data       sample payload or zero-extended overflow count
//   out_chan       channel of the current word
//   out_overflow   1 = overflow message, 0 = sample
//   out_valid      output word valid
//   out_ready      sink accepts the word
module osd_tracesample_mc
    import osd_tracesample_pkg::*;
#(
    parameter  int unsigned WIDTH = 16,
    parameter  int unsigned NCH   = 4,
    parameter  int unsigned OVW   = 10,
    localparam int unsigned CHW   = chw_calc(NCH)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NCH*WIDTH-1:0] sample_data,
    input  logic [NCH-1:0]     sample_valid,
    output logic [WIDTH-1:0]   out_data,
    output logic [CHW-1:0]     out_chan,
    output logic               out_overflow,
    output logic               out_valid,
    input  logic               out_ready
);

    logic [NCH-1:0]            req;
    logic [NCH-1:0]            ch_ov;
    logic [NCH-1:0]            xfer;
    logic [NCH-1:0][WIDTH-1:0] ch_data;

    logic [CHW-1:0] ptr_q;
    logic           lock_q;
    logic [CHW-1:0] lock_chan_q;
    logic [CHW-1:0] rr_pick;
    logic           rr_found;
    int unsigned    idx;
    logic [CHW-1:0] grant;
    logic           any_req;
    logic           transfer;

    for (genvar i = 0; i < NCH; i++) begin : g_chan
        osd_tracesample_chan #(
            .WIDTH (WIDTH),
            .OVW   (OVW)
        ) u_chan (
            .clk          (clk),
            .rst_n        (rst_n),
            .sample_data  (sample_data[i*WIDTH +: WIDTH]),
            .sample_valid (sample_valid[i]),
            .xfer         (xfer[i]),
            .req          (req[i]),
            .req_data     (ch_data[i]),
            .req_overflow (ch_ov[i])
        );
    end

    // First requester at or after ptr_q, wrapping at NCH.
    always_comb begin
        rr_pick  = ptr_q;
        rr_found = 1'b0;
        idx      = 0;
        for (int unsigned k = 0; k < NCH; k++) begin
            idx = 32'(ptr_q) + k;
            if (idx >= NCH) idx = idx - NCH;
            if (!rr_found && req[CHW'(idx)]) begin
                rr_found = 1'b1;
                rr_pick  = CHW'(idx);
            end
        end
    end

    // A stalled channel keeps requesting until accepted, so the locked
    // grant always points at a live request.
    always_comb begin
        any_req  = |req;
        grant    = lock_q ? lock_chan_q : rr_pick;
        transfer = any_req && out_ready;
        xfer     = '0;
        for (int unsigned i = 0; i < NCH; i++) begin
            xfer[i] = transfer && (grant == CHW'(i));
        end
    end

    always_comb begin
        out_valid    = any_req;
        out_chan     = any_req ? grant : '0;
        out_data     = any_req ? ch_data[grant] : '0;
        out_overflow = any_req && ch_ov[grant];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q       <= '0;
            lock_q      <= 1'b0;
            lock_chan_q <= '0;
        end else begin
            lock_q      <= any_req && !out_ready;
            lock_chan_q <= grant;
            if (transfer) begin
                ptr_q <= (grant == CHW'(NCH - 1)) ? '0 : grant + CHW'(1);
            end
        end
    end

endmodule

// File: tb/tb_osd_tracesample_mc.sv
// Self-checking bench for osd_tracesample_mc with a transaction-level
// reference model: each channel holds an optional pending sample and a
// pending drop count; on acceptance the head message is removed, then a new
// sample is stored only if nothing at all is pending, otherwise counted.
module tb_osd_tracesample_mc;

    localparam int unsigned W    = 16;
    localparam int unsigned NCH  = 4;
    localparam int unsigned OVW  = 4;
    localparam int unsigned CHW  = 2;
    localparam int          CMAX = (1 << OVW) - 1;
    localparam int unsigned OW   = W + CHW + 2;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic [NCH*W-1:0]   sample_data = '0;
    logic [NCH-1:0]     sample_valid = '0;
    logic               out_ready = 1'b0;
    logic [W-1:0]       out_data;
    logic [CHW-1:0]     out_chan;
    logic               out_overflow;
    logic               out_valid;

    osd_tracesample_mc #(
        .WIDTH (W),
        .NCH   (NCH),
        .OVW   (OVW)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .sample_data  (sample_data),
        .sample_valid (sample_valid),
        .out_data     (out_data),
        .out_chan     (out_chan),
        .out_overflow (out_overflow),
        .out_valid    (out_valid),
        .out_ready    (out_ready)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // reference model state
    bit         m_has [NCH];
    logic [W-1:0] m_buf [NCH];
    int         m_cnt [NCH];
    int         m_ptr;
    bit         m_locked;
    int         m_lock_chan;

    // expected outputs
    logic         e_valid;
    logic         e_ov;
    logic [W-1:0] e_data;
    logic [CHW-1:0] e_chan_l;
    int           e_chan;

    function automatic logic [OW-1:0] obs_word();
        return {out_valid, out_overflow, out_chan, out_data};
    endfunction

    function automatic logic [OW-1:0] exp_word();
        return {e_valid, e_ov, e_chan_l, e_data};
    endfunction

    task automatic model_outputs();
        int  c;
        bit  found;
        c = 0;
        found = 0;
        e_valid = 0; e_ov = 0; e_data = '0; e_chan_l = '0; e_chan = 0;
        if (m_locked) begin
            c = m_lock_chan;
            found = 1;
        end else begin
            for (int k = 0; k < NCH; k++) begin
                int i;
                i = (m_ptr + k) % NCH;
                if (!found && (m_has[i] || m_cnt[i] > 0)) begin
                    found = 1;
                    c = i;
                end
            end
        end
        if (found) begin
            e_valid  = 1;
            e_chan   = c;
            e_chan_l = c[CHW-1:0];
            if (m_has[c]) e_data = m_buf[c];
            else begin
                e_ov   = 1;
                e_data = W'(m_cnt[c]);
            end
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NCH; i++) begin
            m_has[i] = 0;
            m_buf[i] = '0;
            m_cnt[i] = 0;
        end
        m_ptr = 0;
        m_locked = 0;
        m_lock_chan = 0;
        model_outputs();
    endtask

    function automatic logic [NCH*W-1:0] rand_data();
        logic [NCH*W-1:0] d;
        for (int i = 0; i < NCH; i++) d[i*W +: W] = W'($urandom);
        return d;
    endfunction

    // Drives one cycle of stimulus, advances the model across the edge and
    // leaves time at 1 unit after the rising edge.
    task automatic step(input logic [NCH-1:0] sv, input logic [NCH*W-1:0] sd, input logic rdy);
        sample_valid = sv;
        sample_data  = sd;
        out_ready    = rdy;
        if (e_valid && rdy) begin
            if (m_has[e_chan]) m_has[e_chan] = 0;
            else               m_cnt[e_chan] = 0;
            m_ptr    = (e_chan + 1) % NCH;
            m_locked = 0;
        end else if (e_valid) begin
            m_locked    = 1;
            m_lock_chan = e_chan;
        end
        for (int i = 0; i < NCH; i++) begin
            if (sv[i]) begin
                if (!m_has[i] && m_cnt[i] == 0) begin
                    m_has[i] = 1;
                    m_buf[i] = sd[i*W +: W];
                end else if (m_cnt[i] < CMAX) begin
                    m_cnt[i] = m_cnt[i] + 1;
                end
            end
        end
        @(posedge clk);
        #1;
        model_outputs();
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        sample_valid = '0;
        out_ready = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        #1;
        checks++;
        if (obs_word() !== '0) begin
            errors++;
            $display("FAIL reset_state: got %h expected %h", obs_word(), {OW{1'b0}});
        end
        apply_reset();
        checks++;
        if (obs_word() !== '0) begin
            errors++;
            $display("FAIL reset_release: got %h expected %h", obs_word(), {OW{1'b0}});
        end
    endtask

    task automatic test_latency();
        logic [NCH*W-1:0] sd;
        sd = '0;
        sd[W-1:0] = 16'h1234;
        step(4'b0001, sd, 1'b1);
        checks++;
        if (obs_word() !== exp_word() || out_data !== 16'h1234 || out_overflow !== 1'b0 || out_valid !== 1'b1) begin
            errors++;
            $display("FAIL latency: got %h expected %h (data 1234)", obs_word(), exp_word());
        end
        step('0, '0, 1'b1);
        checks++;
        if (obs_word() !== exp_word() || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL latency_drain: got %h expected %h", obs_word(), exp_word());
        end
    endtask

    task automatic test_hold_overflow();
        logic [NCH*W-1:0] sd;
        sd = '0;
        sd[W-1:0] = 16'hA5A5;
        step(4'b0001, sd, 1'b0);
        for (int n = 0; n < 3; n++) begin
            step(4'b0001, rand_data(), 1'b0);
            checks++;
            if (obs_word() !== exp_word() || out_data !== 16'hA5A5 || out_overflow !== 1'b0) begin
                errors++;
                $display("FAIL hold_sample[%0d]: got %h expected %h", n, obs_word(), exp_word());
            end
        end
        step('0, '0, 1'b1);
        checks++;
        if (obs_word() !== exp_word() || out_overflow !== 1'b1 || out_data !== 16'd3) begin
            errors++;
            $display("FAIL hold_ovmsg: got %h expected %h (count 3)", obs_word(), exp_word());
        end
        step('0, '0, 1'b1);
        checks++;
        if (obs_word() !== exp_word() || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL hold_idle: got %h expected %h", obs_word(), exp_word());
        end
    endtask

    task automatic test_saturate();
        logic [NCH*W-1:0] sd;
        sd = '0;
        sd[W-1:0] = 16'h0BEE;
        step(4'b0001, sd, 1'b0);
        for (int n = 0; n < 20; n++) step(4'b0001, rand_data(), 1'b0);
        checks++;
        if (obs_word() !== exp_word() || out_data !== 16'h0BEE) begin
            errors++;
            $display("FAIL sat_hold: got %h expected %h", obs_word(), exp_word());
        end
        step('0, '0, 1'b1);
        checks++;
        if (obs_word() !== exp_word() || out_overflow !== 1'b1 || out_data !== 16'd15) begin
            errors++;
            $display("FAIL sat_count: got %h expected %h (count 15)", obs_word(), exp_word());
        end
        step('0, '0, 1'b1);
        checks++;
        if (obs_word() !== exp_word() || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL sat_idle: got %h expected %h", obs_word(), exp_word());
        end
    endtask

    task automatic test_ov_resample();
        logic [NCH*W-1:0] sd;
        sd = '0;
        sd[W-1:0] = 16'h1111;
        step(4'b0001, sd, 1'b0);
        step(4'b0001, rand_data(), 1'b0);
        step('0, '0, 1'b1);
        checks++;
        if (obs_word() !== exp_word() || out_overflow !== 1'b1 || out_data !== 16'd1) begin
            errors++;
            $display("FAIL ovres_msg: got %h expected %h", obs_word(), exp_word());
        end
        sd[W-1:0] = 16'h2222;
        step(4'b0001, sd, 1'b1);
        checks++;
        if (obs_word() !== exp_word() || out_overflow !== 1'b0 || out_data !== 16'h2222) begin
            errors++;
            $display("FAIL ovres_new: got %h expected %h", obs_word(), exp_word());
        end
        step('0, '0, 1'b1);
        checks++;
        if (obs_word() !== exp_word() || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL ovres_nodrop: got %h expected %h", obs_word(), exp_word());
        end
    endtask

    task automatic test_grant_lock();
        apply_reset();
        step(4'b0100, rand_data(), 1'b0);
        step(4'b0001, rand_data(), 1'b0);
        checks++;
        if (obs_word() !== exp_word() || out_chan !== 2'd2) begin
            errors++;
            $display("FAIL lock_hold: got %h expected %h", obs_word(), exp_word());
        end
        step('0, '0, 1'b1);
        checks++;
        if (obs_word() !== exp_word() || out_chan !== 2'd0 || out_valid !== 1'b1) begin
            errors++;
            $display("FAIL lock_next: got %h expected %h", obs_word(), exp_word());
        end
        step('0, '0, 1'b1);
    endtask

    task automatic test_round_robin();
        apply_reset();
        step('1, rand_data(), 1'b1);
        for (int k = 0; k < 40; k++) begin
            checks++;
            if (obs_word() !== exp_word() || out_chan !== CHW'(k % NCH)) begin
                errors++;
                $display("FAIL rr[%0d]: got %h expected %h", k, obs_word(), exp_word());
            end
            step('1, rand_data(), 1'b1);
        end
        for (int k = 0; k < 12; k++) begin
            step('0, '0, 1'b1);
            checks++;
            if (obs_word() !== exp_word()) begin
                errors++;
                $display("FAIL rr_drain[%0d]: got %h expected %h", k, obs_word(), exp_word());
            end
        end
    endtask

    task automatic test_random();
        for (int k = 0; k < 400; k++) begin
            step(NCH'($urandom_range(0, 15)), rand_data(), ($urandom_range(0, 3) != 0));
            checks++;
            if (obs_word() !== exp_word()) begin
                errors++;
                $display("FAIL random[%0d]: got %h expected %h", k, obs_word(), exp_word());
            end
        end
    endtask

    task automatic test_reset_midop();
        apply_reset();
        step('1, rand_data(), 1'b0);
        step('1, rand_data(), 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (obs_word() !== '0) begin
            errors++;
            $display("FAIL midrst_async: got %h expected %h", obs_word(), {OW{1'b0}});
        end
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            step('0, '0, 1'b1);
            checks++;
            if (obs_word() !== exp_word() || out_valid !== 1'b0) begin
                errors++;
                $display("FAIL midrst_stale[%0d]: got %h expected %h", k, obs_word(), exp_word());
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_latency();
        test_hold_overflow();
        test_saturate();
        test_ov_resample();
        test_grant_lock();
        test_round_robin();
        test_random();
        test_reset_midop();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
